// File: rtl/binary_to_png_pkg.sv
// Shared constants and helpers for the PNG scanline filter block.
// Filter-type codes follow the PNG filter byte encoding.
package binary_to_png_pkg;

  localparam int PIX_W = 8;

  localparam int NONE    = 0;
  localparam int SUB     = 1;
  localparam int UP      = 2;
  localparam int AVERAGE = 3;
  localparam int PAETH   = 4;

  typedef logic [PIX_W-1:0] pix_t;

  function automatic pix_t avg_pred(
    input pix_t a,
    input pix_t b
  );
    logic [PIX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PIX_W:1];
  endfunction

endpackage

// File: rtl/binary_to_png_if.sv
// Pixel stream bundle: raw sample in, filtered byte and valid out.
// The source side is the master, the filter block is the slave.
interface binary_to_png_if;
  import binary_to_png_pkg::*;

  pix_t binary_pixel;
  pix_t png_pixel;
  logic png_valid;

  modport master (
    output binary_pixel,
    input  png_pixel,
    input  png_valid
  );

  modport slave (
    input  binary_pixel,
    output png_pixel,
    output png_valid
  );

endinterface

// File: rtl/png_paeth_predictor.sv
// Combinational PNG Paeth predictor.
// Ties resolve in a, b, c order.
module png_paeth_predictor
  import binary_to_png_pkg::*;
(
  input  pix_t a,
  input  pix_t b,
  input  pix_t c,
  output pix_t pred
);

  logic signed [10:0] p;
  logic signed [10:0] da;
  logic signed [10:0] db;
  logic signed [10:0] dc;
  logic signed [10:0] pa;
  logic signed [10:0] pb;
  logic signed [10:0] pc;

  always_comb begin
    p  = $signed({3'b000, a})
       + $signed({3'b000, b})
       - $signed({3'b000, c});
    da = p - $signed({3'b000, a});
    db = p - $signed({3'b000, b});
    dc = p - $signed({3'b000, c});
    pa = (da < 0) ? -da : da;
    pb = (db < 0) ? -db : db;
    pc = (dc < 0) ? -dc : dc;
    if (pa <= pb && pa <= pc) begin
      pred = a;
    end else if (pb <= pc) begin
      pred = b;
    end else begin
      pred = c;
    end
  end

endmodule

// File: rtl/binary_to_png.sv
// Streaming PNG scanline filter: one raw grayscale pixel in per clock,
// one filtered byte out one cycle later.
module binary_to_png
  import binary_to_png_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int FILTER = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] binary_pixel,
  output logic [7:0] png_pixel,
  output logic       png_valid
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [XW-1:0] x_q;
  logic [XW-1:0] x_d;
  logic          first_q;
  logic          first_d;
  pix_t          left_q;
  pix_t          upleft_q;
  pix_t          pix_q;
  pix_t          pix_d;
  logic          valid_q;

  pix_t line_mem [WIDTH];

  logic last_col;
  pix_t up_raw;
  pix_t a;
  pix_t b;
  pix_t c;
  pix_t paeth;
  pix_t pred;

  assign last_col = (x_q == XW'(WIDTH - 1));
  assign up_raw   = line_mem[x_q];

  // Stale buffer data is masked on the first row instead of cleared.
  assign a = (x_q == '0) ? '0 : left_q;
  assign b = first_q ? '0 : up_raw;
  assign c = (x_q == '0) ? '0 : upleft_q;

  png_paeth_predictor u_paeth (
    .a    (a),
    .b    (b),
    .c    (c),
    .pred (paeth)
  );

  always_comb begin
    pred = '0;
    case (FILTER)
      SUB:     pred = a;
      UP:      pred = b;
      AVERAGE: pred = avg_pred(a, b);
      PAETH:   pred = paeth;
      default: pred = '0;
    endcase
  end

  always_comb begin
    x_d     = last_col ? '0 : x_q + XW'(1);
    first_d = first_q & ~last_col;
    pix_d   = binary_pixel - pred;
  end

  // Read of the old row happens combinationally before this write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_mem[x_q] <= binary_pixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= '0;
      first_q  <= 1'b1;
      left_q   <= '0;
      upleft_q <= '0;
      pix_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      first_q  <= first_d;
      left_q   <= binary_pixel;
      upleft_q <= b;
      pix_q    <= pix_d;
      valid_q  <= 1'b1;
    end
  end

  assign png_pixel = pix_q;
  assign png_valid = valid_q;

endmodule

// File: tb/tb_binary_to_png.sv
// Directed bench: five filter configurations run side by side,
// sharing clock and reset, each fed its own pixel stream.
module tb_binary_to_png;
  import binary_to_png_pkg::*;

  logic clk;
  logic rst;

  int total;
  int bad;

  binary_to_png_if if0 ();
  binary_to_png_if if1 ();
  binary_to_png_if if2 ();
  binary_to_png_if if3 ();
  binary_to_png_if if4 ();

  binary_to_png #(.WIDTH(8), .FILTER(0)) u0 (
    .clk(clk), .rst(rst),
    .binary_pixel(if0.binary_pixel),
    .png_pixel(if0.png_pixel),
    .png_valid(if0.png_valid)
  );

  binary_to_png #(.WIDTH(8), .FILTER(1)) u1 (
    .clk(clk), .rst(rst),
    .binary_pixel(if1.binary_pixel),
    .png_pixel(if1.png_pixel),
    .png_valid(if1.png_valid)
  );

  binary_to_png #(.WIDTH(4), .FILTER(2)) u2 (
    .clk(clk), .rst(rst),
    .binary_pixel(if2.binary_pixel),
    .png_pixel(if2.png_pixel),
    .png_valid(if2.png_valid)
  );

  binary_to_png #(.WIDTH(2), .FILTER(3)) u3 (
    .clk(clk), .rst(rst),
    .binary_pixel(if3.binary_pixel),
    .png_pixel(if3.png_pixel),
    .png_valid(if3.png_valid)
  );

  binary_to_png #(.WIDTH(2), .FILTER(4)) u4 (
    .clk(clk), .rst(rst),
    .binary_pixel(if4.binary_pixel),
    .png_pixel(if4.png_pixel),
    .png_valid(if4.png_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in2 [7] = '{8'h10, 8'h20, 8'h30, 8'h40,
                          8'h11, 8'h22, 8'h33};
  logic [7:0] ex1 [7] = '{8'hFF, 8'h00, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00};
  logic [7:0] ex2 [7] = '{8'h10, 8'h20, 8'h30, 8'h40,
                          8'h01, 8'h02, 8'h03};
  logic [7:0] ex3 [7] = '{8'h10, 8'h18, 8'h08, 8'h08,
                          8'h08, 8'h08, 8'h08};
  logic [7:0] ex4 [7] = '{8'hAA, 8'hAB, 8'h00, 8'h00,
                          8'h00, 8'h00, 8'h00};

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_v0"}, {7'd0, if0.png_valid}, 8'h00);
    chk({tag, "_p0"}, if0.png_pixel, 8'h00);
    chk({tag, "_v1"}, {7'd0, if1.png_valid}, 8'h00);
    chk({tag, "_p1"}, if1.png_pixel, 8'h00);
    chk({tag, "_v2"}, {7'd0, if2.png_valid}, 8'h00);
    chk({tag, "_p2"}, if2.png_pixel, 8'h00);
    chk({tag, "_v3"}, {7'd0, if3.png_valid}, 8'h00);
    chk({tag, "_p3"}, if3.png_pixel, 8'h00);
    chk({tag, "_v4"}, {7'd0, if4.png_valid}, 8'h00);
    chk({tag, "_p4"}, if4.png_pixel, 8'h00);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    if0.binary_pixel = 8'h55;
    if1.binary_pixel = 8'hFF;
    if2.binary_pixel = 8'h00;
    if3.binary_pixel = 8'h00;
    if4.binary_pixel = 8'h00;

    #10;
    chk_reset("rst_init");
    rst = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if0.binary_pixel = 8'h55;
      if1.binary_pixel = 8'hFF;
      if2.binary_pixel = in2[i];
      if3.binary_pixel = (i % 2 == 0) ? 8'h10 : 8'h20;
      if4.binary_pixel = (i % 2 == 0) ? 8'hAA : 8'h55;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("none_v%0d", i),
          {7'd0, if0.png_valid}, 8'h01);
      chk($sformatf("none_p%0d", i), if0.png_pixel, 8'h55);
      chk($sformatf("sub_p%0d", i), if1.png_pixel, ex1[i]);
      chk($sformatf("up_p%0d", i), if2.png_pixel, ex2[i]);
      chk($sformatf("avg_p%0d", i), if3.png_pixel, ex3[i]);
      chk($sformatf("paeth_p%0d", i), if4.png_pixel, ex4[i]);
      chk($sformatf("paeth_v%0d", i),
          {7'd0, if4.png_valid}, 8'h01);
    end

    // Up-filter block now sits at column 3 of row 1.
    rst = 1'b0;
    #1;
    chk_reset("rst_mid");
    @(posedge clk);
    @(negedge clk);
    chk_reset("rst_hold");

    rst = 1'b1;
    if1.binary_pixel = 8'hFF;
    if2.binary_pixel = 8'h77;
    if4.binary_pixel = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    chk("post_up_v", {7'd0, if2.png_valid}, 8'h01);
    chk("post_up_x0", if2.png_pixel, 8'h77);
    chk("post_sub_x0", if1.png_pixel, 8'hFF);
    chk("post_paeth_x0", if4.png_pixel, 8'hAA);

    if2.binary_pixel = 8'h66;
    if4.binary_pixel = 8'h55;
    @(posedge clk);
    @(negedge clk);
    chk("post_up_x1", if2.png_pixel, 8'h66);
    chk("post_paeth_x1", if4.png_pixel, 8'hAB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/binary_to_png.md
BINARY_TO_PNG -- requirements
Module: binary_to_png

Interface
REQ-001 Parameter WIDTH, default 8: pixels per scanline, legal range 2..4096.
REQ-002 Parameter FILTER, default 1: PNG filter type, where 0=None, 1=Sub, 2=Up, 3=Average, 4=Paeth.
REQ-003 Port clk, input, 1 bit: single clock; all logic is rising-edge triggered.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port binary_pixel, input, 8 bits: raw grayscale sample, sampled on every rising edge while rst is high.
REQ-006 Port png_pixel, output, 8 bits: PNG-filtered byte for the most recently sampled pixel.
REQ-007 Port png_valid, output, 1 bit: high when png_pixel holds a filtered byte.

Function
REQ-008 The block SHALL accept one pixel per clock with no stall and no input handshake.
REQ-009 Pixels SHALL be in raster order, WIDTH per row; column x wraps from WIDTH-1 to 0 and advances the row.
REQ-010 Latency SHALL be 1 cycle: pixel sampled at edge N appears on png_pixel/png_valid after edge N, registered.
REQ-011 png_valid SHALL rise after the first post-reset sampling edge and stay high until the next reset.
REQ-012 Define a=left raw, b=up raw, c=up-left raw; a=c=0 at x=0; b=c=0 on the first row after reset.
REQ-013 Output SHALL be raw minus the predictor, modulo 256.
REQ-014 Predictors: None=0; Sub=a; Up=b; Average=floor((a+b)/2) using a 9-bit sum.
REQ-015 Paeth predictor: p=a+b-c in at least 10-bit signed; pa=|p-a|, pb=|p-b|, pc=|p-c|.
REQ-016 Paeth selection: choose a if pa<=pb and pa<=pc, else b if pb<=pc, else c.
REQ-017 The block SHALL keep a WIDTH x 8 line buffer of the previous row's raw pixels, written at column x as each pixel is consumed.
REQ-018 The first row SHALL be indicated by a flag rather than by clearing the buffer; the flag clears at the first wrap to x=0.
REQ-019 Invalid FILTER values SHALL behave as None.
REQ-020 No PNG headers, filter-type bytes, or CRC/zlib data are emitted; the output stream is filtered pixel data only.

Reset
REQ-021 While rst is low: png_pixel=0x00, png_valid=0, x=0, first-row flag=1, left and up-left registers=0.
REQ-022 Reset asserted mid-row SHALL take effect immediately; after release, processing restarts at row 0, x=0.
REQ-023 Line-buffer contents SHALL NOT be reset; the first-row flag masks them.

Structure
REQ-024 Package binary_to_png_pkg SHALL hold the filter-type constants (NONE..PAETH) and the pixel width constant (8).
REQ-025 The Paeth predictor SHALL be a combinational sub-module png_paeth_predictor with inputs a, b, c and output pred.
REQ-026 The line buffer SHALL be inferable as a single-port RAM with read-before-write.

Verification
REQ-027 FILTER=0, rst low 10 ns then high, binary_pixel=0x55 constant -> png_valid=1 and png_pixel=0x55 on every cycle after the first sampling edge.
REQ-028 FILTER=1, WIDTH=8, constant 0xFF -> each row outputs FF,00,00,00,00,00,00,00.
REQ-029 FILTER=2, WIDTH=4, rows 10,20,30,40 then 11,22,33,44 -> outputs 10,20,30,40 then 01,02,03,04.
REQ-030 FILTER=3, WIDTH=2, row 10,20 -> outputs 10,18.
REQ-031 FILTER=4, WIDTH=2, rows AA,55 then AA,55 -> outputs AA,AB then 00,00.
REQ-032 Reset pulsed at x=3 of row 1 -> png_valid=0 and png_pixel=00 immediately; the next pixel is treated as row 0, x=0 (Up-filter output equals raw).
